// File: rtl/video_daisy_ctrl.sv
// Frame-synchronous shadow/staging/active register controller for the video daisy chain.
// Host writes land in shadow registers; a per-frame FSM commits, auto-moves sprites and applies atomically.
module video_daisy_ctrl #(
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int SPRITE_HSIZE = 32,
    parameter int SPRITE_VSIZE = 32,
    parameter int HW           = 11,
    parameter int VW           = 10
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          frame_start,
    input  logic          stall,
    input  logic          host_wr,
    input  logic          host_rd,
    input  logic [2:0]    host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          host_rdata_vld,
    output logic          bar_core_bypass,
    output logic          pikachu_core_bypass,
    output logic          pacman_core_bypass,
    output logic          rgb2gray_core_bypass,
    output logic [HW-1:0] pikachu_x0,
    output logic [HW-1:0] pacman_x0,
    output logic [VW-1:0] pikachu_y0,
    output logic [VW-1:0] pacman_y0,
    output logic [31:0]   sprite_rate,
    output logic [15:0]   frame_cnt
);

    localparam logic signed [HW:0] XMAX = (HW+1)'(H_DISPLAY - SPRITE_HSIZE);
    localparam logic signed [VW:0] YMAX = (VW+1)'(V_DISPLAY - SPRITE_VSIZE);
    localparam logic [31:0]        RATE_RST = 32'd10_000_000;

    typedef enum logic [2:0] {S_IDLE, S_COMMIT, S_MOVE_PIKA, S_MOVE_PAC, S_APPLY} state_t;

    state_t        r_state, w_nxt;
    logic          w_fs_q;
    logic          r_pend;
    logic [15:0]   r_cnt;
    logic [31:0]   r_rdata, w_rdata;
    logic          r_rdata_vld;

    // ctrl: [3:0] bypass {rgb2gray,pacman,pikachu,bar}, [4] pika auto, [5] pac auto
    logic [5:0]    r_sh_ctrl, r_st_ctrl;
    logic [HW-1:0] r_sh_pika_x, r_st_pika_x, r_act_pika_x;
    logic [VW-1:0] r_sh_pika_y, r_st_pika_y, r_act_pika_y;
    logic [HW-1:0] r_sh_pac_x, r_st_pac_x, r_act_pac_x;
    logic [VW-1:0] r_sh_pac_y, r_st_pac_y, r_act_pac_y;
    logic [7:0]    r_sh_pika_dx, r_sh_pika_dy, r_sh_pac_dx, r_sh_pac_dy;
    logic [7:0]    r_st_pika_dx, r_st_pika_dy, r_st_pac_dx, r_st_pac_dy;
    logic [31:0]   r_sh_rate, r_st_rate, r_act_rate;
    logic [3:0]    r_act_byp;
    logic          w_unused;

    assign w_fs_q   = frame_start & ~stall;
    assign w_unused = &{1'b0, host_wdata};

    function automatic logic [7:0] neg8(input logic [7:0] d);
        return (d == 8'h80) ? 8'h7f : (~d + 8'd1);
    endfunction

    function automatic logic [HW+7:0] step_x(input logic [HW-1:0] p, input logic [7:0] d);
        logic signed [HW:0] n;
        n = $signed({1'b0, p}) + $signed({{(HW-7){d[7]}}, d});
        if (n < 0)         return {{HW{1'b0}}, neg8(d)};
        else if (n > XMAX) return {XMAX[HW-1:0], neg8(d)};
        else               return {n[HW-1:0], d};
    endfunction

    function automatic logic [VW+7:0] step_y(input logic [VW-1:0] p, input logic [7:0] d);
        logic signed [VW:0] n;
        n = $signed({1'b0, p}) + $signed({{(VW-7){d[7]}}, d});
        if (n < 0)         return {{VW{1'b0}}, neg8(d)};
        else if (n > YMAX) return {YMAX[VW-1:0], neg8(d)};
        else               return {n[VW-1:0], d};
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_fs_q) w_nxt = r_pend ? S_COMMIT : S_MOVE_PIKA;
            S_COMMIT:    w_nxt = S_MOVE_PIKA;
            S_MOVE_PIKA: w_nxt = S_MOVE_PAC;
            S_MOVE_PAC:  w_nxt = S_APPLY;
            S_APPLY:     w_nxt = S_IDLE;
            default:     w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sh_ctrl    <= '0;
            r_sh_pika_x  <= HW'(32);
            r_sh_pika_y  <= VW'(32);
            r_sh_pac_x   <= HW'(64);
            r_sh_pac_y   <= VW'(64);
            r_sh_pika_dx <= '0;
            r_sh_pika_dy <= '0;
            r_sh_pac_dx  <= '0;
            r_sh_pac_dy  <= '0;
            r_sh_rate    <= RATE_RST;
        end else if (host_wr) begin
            case (host_addr)
                3'd0: r_sh_ctrl <= host_wdata[5:0];
                3'd1: begin r_sh_pika_x <= host_wdata[HW-1:0]; r_sh_pika_y <= host_wdata[16+:VW]; end
                3'd2: begin r_sh_pac_x  <= host_wdata[HW-1:0]; r_sh_pac_y  <= host_wdata[16+:VW]; end
                3'd3: begin r_sh_pika_dx <= host_wdata[7:0]; r_sh_pika_dy <= host_wdata[15:8]; end
                3'd4: begin r_sh_pac_dx  <= host_wdata[7:0]; r_sh_pac_dy  <= host_wdata[15:8]; end
                3'd5: r_sh_rate <= host_wdata;
                default: ;
            endcase
        end
    end

    // A new commit request landing while COMMIT clears the old one must survive.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                                       r_pend <= 1'b0;
        else if (host_wr && host_addr == 3'd7 && host_wdata[0]) r_pend <= 1'b1;
        else if (r_state == S_COMMIT)                         r_pend <= 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  r_cnt <= '0;
        else if (w_fs_q) r_cnt <= r_cnt + 16'd1;
    end

    always_comb begin
        w_rdata = '0;
        case (host_addr)
            3'd0: w_rdata[5:0] = r_sh_ctrl;
            3'd1: begin w_rdata[HW-1:0] = r_sh_pika_x; w_rdata[16+:VW] = r_sh_pika_y; end
            3'd2: begin w_rdata[HW-1:0] = r_sh_pac_x;  w_rdata[16+:VW] = r_sh_pac_y;  end
            3'd3: w_rdata[15:0] = {r_sh_pika_dy, r_sh_pika_dx};
            3'd4: w_rdata[15:0] = {r_sh_pac_dy, r_sh_pac_dx};
            3'd5: w_rdata = r_sh_rate;
            3'd6: w_rdata[16:0] = {r_pend, r_cnt};
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
        end else begin
            r_rdata_vld <= host_rd;
            if (host_rd) r_rdata <= w_rdata;
        end
    end

    // Staging velocity is the velocity in effect; bounces never reach the shadow copy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_st_ctrl    <= '0;
            r_st_pika_x  <= HW'(32);
            r_st_pika_y  <= VW'(32);
            r_st_pac_x   <= HW'(64);
            r_st_pac_y   <= VW'(64);
            r_st_pika_dx <= '0;
            r_st_pika_dy <= '0;
            r_st_pac_dx  <= '0;
            r_st_pac_dy  <= '0;
            r_st_rate    <= RATE_RST;
            r_act_byp    <= '0;
            r_act_pika_x <= HW'(32);
            r_act_pika_y <= VW'(32);
            r_act_pac_x  <= HW'(64);
            r_act_pac_y  <= VW'(64);
            r_act_rate   <= RATE_RST;
        end else begin
            case (r_state)
                S_COMMIT: begin
                    r_st_ctrl    <= r_sh_ctrl;
                    r_st_pika_x  <= r_sh_pika_x;
                    r_st_pika_y  <= r_sh_pika_y;
                    r_st_pac_x   <= r_sh_pac_x;
                    r_st_pac_y   <= r_sh_pac_y;
                    r_st_pika_dx <= r_sh_pika_dx;
                    r_st_pika_dy <= r_sh_pika_dy;
                    r_st_pac_dx  <= r_sh_pac_dx;
                    r_st_pac_dy  <= r_sh_pac_dy;
                    r_st_rate    <= r_sh_rate;
                end
                S_MOVE_PIKA: if (r_st_ctrl[4]) begin
                    {r_st_pika_x, r_st_pika_dx} <= step_x(r_st_pika_x, r_st_pika_dx);
                    {r_st_pika_y, r_st_pika_dy} <= step_y(r_st_pika_y, r_st_pika_dy);
                end
                S_MOVE_PAC: if (r_st_ctrl[5]) begin
                    {r_st_pac_x, r_st_pac_dx} <= step_x(r_st_pac_x, r_st_pac_dx);
                    {r_st_pac_y, r_st_pac_dy} <= step_y(r_st_pac_y, r_st_pac_dy);
                end
                S_APPLY: begin
                    r_act_byp    <= r_st_ctrl[3:0];
                    r_act_pika_x <= r_st_pika_x;
                    r_act_pika_y <= r_st_pika_y;
                    r_act_pac_x  <= r_st_pac_x;
                    r_act_pac_y  <= r_st_pac_y;
                    r_act_rate   <= r_st_rate;
                end
                default: ;
            endcase
        end
    end

    assign host_rdata           = r_rdata;
    assign host_rdata_vld       = r_rdata_vld;
    assign bar_core_bypass      = r_act_byp[0];
    assign pikachu_core_bypass  = r_act_byp[1];
    assign pacman_core_bypass   = r_act_byp[2];
    assign rgb2gray_core_bypass = r_act_byp[3];
    assign pikachu_x0           = r_act_pika_x;
    assign pikachu_y0           = r_act_pika_y;
    assign pacman_x0            = r_act_pac_x;
    assign pacman_y0            = r_act_pac_y;
    assign sprite_rate          = r_act_rate;
    assign frame_cnt            = r_cnt;

endmodule

// File: tb/tb_video_daisy_ctrl.sv
// Directed bench for video_daisy_ctrl: register map, commit timing, auto-move bounce, stall, reset abort, wrap.
module tb_video_daisy_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        stall = 1'b0;
    logic        host_wr = 1'b0;
    logic        host_rd = 1'b0;
    logic [2:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        host_rdata_vld;
    logic        bar_core_bypass, pikachu_core_bypass, pacman_core_bypass, rgb2gray_core_bypass;
    logic [10:0] pikachu_x0, pacman_x0;
    logic [9:0]  pikachu_y0, pacman_y0;
    logic [31:0] sprite_rate;
    logic [15:0] frame_cnt;
    logic [3:0]  byp;

    int n_chk = 0;
    int n_err = 0;

    video_daisy_ctrl dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start), .stall(stall),
        .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rdata_vld(host_rdata_vld),
        .bar_core_bypass(bar_core_bypass), .pikachu_core_bypass(pikachu_core_bypass),
        .pacman_core_bypass(pacman_core_bypass), .rgb2gray_core_bypass(rgb2gray_core_bypass),
        .pikachu_x0(pikachu_x0), .pacman_x0(pacman_x0), .pikachu_y0(pikachu_y0), .pacman_y0(pacman_y0),
        .sprite_rate(sprite_rate), .frame_cnt(frame_cnt)
    );

    assign byp = {rgb2gray_core_bypass, pacman_core_bypass, pikachu_core_bypass, bar_core_bypass};

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        host_wr = 1'b1; host_addr = a; host_wdata = d;
        tick(1);
        host_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        host_rd = 1'b1; host_addr = a;
        tick(1);
        host_rd = 1'b0;
        chk({tag, "_vld"}, 32'(host_rdata_vld), 32'd1);
        chk(tag, host_rdata, exp);
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic frame();
        fs_pulse();
        tick(5);
    endtask

    task automatic chk_pika(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(pikachu_x0), 32'(x));
        chk({tag, "_y"}, 32'(pikachu_y0), 32'(y));
    endtask

    task automatic chk_pac(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(pacman_x0), 32'(x));
        chk({tag, "_y"}, 32'(pacman_y0), 32'(y));
    endtask

    initial begin
        // 1: reset values and register readback
        tick(3);
        sys_rst_n = 1'b1;
        tick(1);
        chk("rst_byp", 32'(byp), 32'd0);
        chk_pika("rst_pika", 32, 32);
        chk_pac("rst_pac", 64, 64);
        chk("rst_rate", sprite_rate, 32'd10000000);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rd("rd_ctrl", 3'd0, 32'h0);
        rd("rd_pika_pos", 3'd1, 32'h0020_0020);
        rd("rd_pac_pos", 3'd2, 32'h0040_0040);
        rd("rd_pika_vel", 3'd3, 32'h0);
        rd("rd_rate", 3'd5, 32'd10000000);
        rd("rd_status", 3'd6, 32'h0);
        rd("rd_commit", 3'd7, 32'h0);
        tick(1);
        chk("rd_vld_drop", 32'(host_rdata_vld), 32'd0);

        // 2: shadow writes stay invisible until commit
        wr(3'd0, 32'h9);
        wr(3'd1, 32'h0064_00C8);
        wr(3'd6, 32'hFFFF_FFFF);
        repeat (3) frame();
        chk("nocommit_byp", 32'(byp), 32'd0);
        chk_pika("nocommit_pika", 32, 32);
        chk("cnt3", 32'(frame_cnt), 32'd3);
        wr(3'd7, 32'h1);
        rd("status_pend", 3'd6, 32'h0001_0003);
        fs_pulse();
        tick(3);
        chk("commit_t3_byp", 32'(byp), 32'd0);
        chk("commit_t3_x", 32'(pikachu_x0), 32'd32);
        tick(1);
        chk("commit_t4_byp", 32'(byp), 32'h9);
        chk_pika("commit_t4_pika", 200, 100);
        rd("status_clr", 3'd6, 32'h0000_0004);

        // 3: auto-move bounce on right and top edges
        wr(3'd1, 32'h0000_0258);
        wr(3'd3, 32'h0000_FD0A);
        wr(3'd0, 32'h19);
        wr(3'd7, 32'h1);
        fs_pulse();
        tick(3);
        chk("move_c_t3_x", 32'(pikachu_x0), 32'd200);
        tick(1);
        chk_pika("move_bounce", 608, 0);
        rd("shadow_vel_kept", 3'd3, 32'h0000_FD0A);
        fs_pulse();
        tick(2);
        chk("move_t2_x", 32'(pikachu_x0), 32'd608);
        tick(1);
        chk_pika("move_back", 598, 3);
        tick(3);
        chk("cnt6", 32'(frame_cnt), 32'd6);

        // 4: stall masks frame_start
        stall = 1'b1; frame_start = 1'b1;
        tick(3);
        chk("stall_cnt", 32'(frame_cnt), 32'd6);
        chk("stall_x", 32'(pikachu_x0), 32'd598);
        stall = 1'b0;
        tick(1);
        frame_start = 1'b0;
        tick(5);
        chk("unstall_cnt", 32'(frame_cnt), 32'd7);
        chk_pika("unstall_pika", 588, 6);

        // 5: commit request during COMMIT state survives
        wr(3'd0, 32'h2);
        wr(3'd2, 32'h0032_0064);
        wr(3'd7, 32'h1);
        fs_pulse();
        wr(3'd7, 32'h1);
        tick(2);
        chk("race_t3_pac_x", 32'(pacman_x0), 32'd64);
        tick(1);
        chk("race_byp", 32'(byp), 32'h2);
        chk_pac("race_pac", 100, 50);
        chk_pika("race_pika", 600, 0);
        rd("race_status", 3'd6, 32'h0001_0008);
        wr(3'd2, 32'h0014_000A);
        frame();
        chk_pac("race_second", 10, 20);
        rd("race_status2", 3'd6, 32'h0000_0009);

        // reset during MOVE_PAC aborts the apply
        wr(3'd2, 32'h00C8_012C);
        wr(3'd7, 32'h1);
        fs_pulse();
        tick(2);
        sys_rst_n = 1'b0;
        #1;
        chk_pac("arst_pac", 64, 64);
        chk_pika("arst_pika", 32, 32);
        chk("arst_byp", 32'(byp), 32'd0);
        chk("arst_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_vld", 32'(host_rdata_vld), 32'd0);
        tick(2);
        sys_rst_n = 1'b1;
        tick(5);
        chk_pac("arst_after", 64, 64);
        rd("arst_status", 3'd6, 32'h0);
        rd("arst_pac_pos", 3'd2, 32'h0040_0040);

        // 6: frame counter wrap, and -128 velocity bounce saturating to +127
        frame_start = 1'b1;
        tick(65535);
        frame_start = 1'b0;
        chk("cnt_ffff", 32'(frame_cnt), 32'h0000_FFFF);
        tick(5);
        fs_pulse();
        chk("cnt_wrap", 32'(frame_cnt), 32'd0);
        tick(5);
        wr(3'd2, 32'h0064_0064);
        wr(3'd4, 32'h0000_0080);
        wr(3'd0, 32'h20);
        wr(3'd7, 32'h1);
        frame();
        chk_pac("neg128_clamp", 0, 100);
        frame();
        chk_pac("neg128_sat", 127, 100);
        rd("pac_vel_kept", 3'd4, 32'h0000_0080);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/video_daisy_ctrl.md
Name: video_daisy_ctrl

Overview:
- Frame-synchronous configuration and motion controller for the video daisy chain (bar, pikachu sprite, pacman animated sprite, rgb2gray).
- A host register port writes shadow registers. These are committed atomically to the active outputs at a frame boundary, so bypass, position and rate changes never tear mid-frame.
- Optional per-sprite auto-motion moves each sprite once per frame and bounces it off the screen edges.
- Sits beside the daisy chain. It drives the cores' bypass, x0/y0 and sprite_rate inputs, and samples frame_start and stall.

Parameters:
- H_DISPLAY, 640, visible pixels per line.
- V_DISPLAY, 480, visible lines per frame.
- SPRITE_HSIZE, 32, sprite width in pixels.
- SPRITE_VSIZE, 32, sprite height in lines.
- HW, 11, horizontal coordinate width.
- VW, 10, vertical coordinate width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  frame-start pulse from the frame counter.
- stall  in  1  pipeline stall; a frame boundary is qualified only when stall=0.
- host_wr  in  1  register write strobe.
- host_rd  in  1  register read strobe.
- host_addr  in  3  register index.
- host_wdata  in  32  write data.
- host_rdata  out  32  read data, registered.
- host_rdata_vld  out  1  one-cycle pulse, 1 cycle after host_rd.
- bar_core_bypass, pikachu_core_bypass, pacman_core_bypass, rgb2gray_core_bypass  out  1 each  active bypass controls.
- pikachu_x0, pacman_x0  out  HW  active sprite x origin.
- pikachu_y0, pacman_y0  out  VW  active sprite y origin.
- sprite_rate  out  32  active pacman animation rate.
- frame_cnt  out  16  count of qualified frames.

Behaviour:

Register map (all R/W shadow except where noted):
- 0 CTRL: [3:0] bypass bits (bar, pikachu, pacman, rgb2gray); [4] pikachu auto-move enable; [5] pacman auto-move enable.
- 1 PIKA_POS and 2 PAC_POS: [HW-1:0] x; [16+VW-1:16] y.
- 3 PIKA_VEL and 4 PAC_VEL: [7:0] signed dx; [15:8] signed dy.
- 5 RATE: sprite_rate.
- 6 STATUS, read-only: [15:0] frame_cnt; [16] commit_pending.
- 7 COMMIT, write-only: writing bit0=1 sets commit_pending; reads return 0.
- Unmapped bits read 0. Writes to STATUS are ignored.

Host port:
- host_wr updates the shadow register in the same cycle, is never blocked and never touches active outputs directly.
- Read data appears registered, 1-cycle latency, with a host_rdata_vld pulse.
- Simultaneous host_wr and host_rd to the same address return the old value.

Frame event:
- fs_q = frame_start & ~stall.
- Each fs_q increments frame_cnt, wrapping 0xFFFF->0.

FSM states: IDLE, COMMIT, MOVE_PIKA, MOVE_PAC, APPLY.
- IDLE --fs_q & pending--> COMMIT.
- IDLE --fs_q & ~pending--> MOVE_PIKA.
- COMMIT: copy all shadow registers (bypass, positions, velocities, rate, auto enables) into the staging set; clear pending; go to MOVE_PIKA.
- MOVE_PIKA: update the pikachu staging position if pikachu auto-move is enabled (a commit in the same frame is followed by one move step); go to MOVE_PAC.
- MOVE_PAC: same update for pacman; go to APPLY.
- APPLY: load the staging set into the active outputs all in one cycle; go to IDLE.
- Outputs change exactly 3 cycles after fs_q without a commit, or 4 cycles with a commit.
- fs_q arriving while not in IDLE is ignored by the FSM but still counts in frame_cnt.
- A COMMIT write landing in the same cycle the COMMIT state clears pending leaves pending=1, so the new request wins and applies next frame.

Move arithmetic (per axis, x shown; y uses VW, SPRITE_VSIZE, V_DISPLAY):
- nx = x + sext(dx), computed in HW+1 signed bits.
- XMAX = H_DISPLAY - SPRITE_HSIZE.
- If nx < 0: x = 0 and dx = -dx.
- Else if nx > XMAX: x = XMAX and dx = -dx.
- Else: x = nx.
- Negating -128 saturates to +127.
- Bounce modifies only active and staging velocity; the shadow velocity is unchanged.

Reset (asynchronous, sys_rst_n=0), shadow and active alike:
- All bypass bits 0; auto-move enables 0.
- pikachu position (32,32); pacman position (64,64).
- Velocities 0; sprite_rate 10000000.
- frame_cnt 0; pending 0.
- host_rdata 0; host_rdata_vld 0; FSM IDLE.
- Reset asserted mid-sequence aborts it with no partial apply.

Test Plan:
1. Reset, then read all registers -> CTRL=0, PIKA_POS=0x0020_0020, PAC_POS=0x0040_0040, RATE=10000000, STATUS=0; each read returns host_rdata_vld 1 cycle after host_rd.
2. Write CTRL=0x9 and PIKA_POS=0x0064_00C8 without COMMIT, then run 3 frames -> outputs unchanged. Write COMMIT=1 -> STATUS[16]=1; at the next fs_q+4, bar and rgb2gray bypass=1 and pikachu (200,100), all changing in the same cycle; pending=0.
3. Pikachu auto-move with x=600, dx=+10 (XMAX=608) -> next frame x=608 with dx=-10; following frame x=598. y=0 with dy=-3 -> y=0 with dy=+3.
4. Hold stall=1 across frame_start -> no frame_cnt increment, no FSM activity; release stall with frame_start high -> the event is processed once.
5. Issue a COMMIT write in the same cycle the FSM is in COMMIT -> pending stays 1 and the second shadow set applies next frame. Assert sys_rst_n low during MOVE_PAC -> all outputs return to reset values immediately.
6. Preload frame_cnt to 0xFFFF via 65535 qualified frames (or force) -> next fs_q wraps it to 0; dx=-128 bounce -> dx becomes +127.
